// File: rtl/bus_arb2.sv
// bus_arb2: two-master / one-slave arbiter for the req/ack/resp bus.
// Round-robin arbitration with the grant held until the slave accepts.
// In-order read responses are routed back through a FIFO of master IDs.
module bus_arb2 #(
    parameter int RD_FIFO_POW = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,

    output logic        resp_err_o
);

    localparam int DEPTH = 2 ** RD_FIFO_POW;
    localparam logic [RD_FIFO_POW:0] DEPTH_CNT = (RD_FIFO_POW + 1)'(DEPTH);

    logic                   prio;
    logic                   lock_valid;
    logic                   lock_id;
    logic [RD_FIFO_POW:0]   count;
    logic [RD_FIFO_POW-1:0] wptr;
    logic [RD_FIFO_POW-1:0] rptr;
    logic                   id_mem [DEPTH];

    logic full, empty;
    logic elig0, elig1;
    logic has_win, win_id;
    logic accept, push, pop;
    logic head;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A read is held off while the ID FIFO is full; writes always go through.
    assign elig0 = m0_req_i & (m0_we_i | ~full);
    assign elig1 = m1_req_i & (m1_we_i | ~full);

    // Pick the winner: a held grant sticks, otherwise round-robin on prio.
    always_comb begin
        has_win = 1'b0;
        win_id  = 1'b0;
        if (lock_valid) begin
            win_id  = lock_id;
            has_win = lock_id ? m1_req_i : m0_req_i;
        end else if (elig0 && elig1) begin
            win_id  = prio;
            has_win = 1'b1;
        end else if (elig0 || elig1) begin
            win_id  = elig1;
            has_win = 1'b1;
        end
    end

    // Mux the winning master onto the slave port; zero when idle.
    always_comb begin
        s_req_o    = has_win;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (has_win) begin
            s_we_o     = win_id ? m1_we_i     : m0_we_i;
            s_addr_bo  = win_id ? m1_addr_bi  : m0_addr_bi;
            s_be_bo    = win_id ? m1_be_bi    : m0_be_bi;
            s_wdata_bo = win_id ? m1_wdata_bi : m0_wdata_bi;
        end
    end

    assign accept   = s_req_o & s_ack_i;
    assign push     = accept & ~s_we_o;
    assign pop      = s_resp_i & ~empty;
    assign head     = id_mem[rptr];
    assign m0_ack_o = accept & ~win_id;
    assign m1_ack_o = accept &  win_id;

    // Route a response to the master at the FIFO head; flag orphan responses.
    always_comb begin
        m0_resp_o   = pop & ~head;
        m1_resp_o   = pop &  head;
        m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
        m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
        resp_err_o  = s_resp_i & empty;
    end

    // Arbitration state and FIFO bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio       <= 1'b0;
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            if (accept) begin
                lock_valid <= 1'b0;
                prio       <= ~win_id;
            end else if (s_req_o) begin
                lock_valid <= 1'b1;
                lock_id    <= win_id;
            end
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wptr] <= win_id;
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed bench for bus_arb2: round-robin, grant lock, FIFO full,
// push/pop at full, orphan response and mid-transaction reset.
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack, s_resp, resp_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_arb2 #(.RD_FIFO_POW(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
        .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
        .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be),
        .s_wdata_bo(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .resp_err_o(resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_be = 4'hF; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_be = 4'hF; m1_wdata = 0;
        s_ack = 0; s_resp = 0; s_rdata = 0;
        tick(); tick();

        // Reset state
        settle();
        chk("rst_s_req",    32'(s_req),    0);
        chk("rst_m0_ack",   32'(m0_ack),   0);
        chk("rst_m1_ack",   32'(m1_ack),   0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_s_addr",   s_addr,        0);
        chk("rst_m0_rdata", m0_rdata,      0);
        chk("rst_prio",     32'(dut.prio), 0);
        rst = 1'b0;
        tick();

        // Round-robin: both read, slave acks every cycle, responds 2 cycles later
        m0_req = 1; m0_we = 0; m0_addr = 32'h8000_0000;
        m1_req = 1; m1_we = 0; m1_addr = 32'h8000_0004;
        s_ack = 1;
        settle();
        chk("rr0_m0_ack", 32'(m0_ack), 1);
        chk("rr0_m1_ack", 32'(m1_ack), 0);
        chk("rr0_addr",   s_addr, 32'h8000_0000);
        tick();
        settle();
        chk("rr1_m1_ack", 32'(m1_ack), 1);
        chk("rr1_m0_ack", 32'(m0_ack), 0);
        chk("rr1_addr",   s_addr, 32'h8000_0004);
        tick();
        s_resp = 1; s_rdata = 32'h1111_1111;
        settle();
        chk("rr2_m0_ack",   32'(m0_ack),  1);
        chk("rr2_m0_resp",  32'(m0_resp), 1);
        chk("rr2_m0_rdata", m0_rdata, 32'h1111_1111);
        chk("rr2_m1_resp",  32'(m1_resp), 0);
        chk("rr2_m1_rdata", m1_rdata, 0);
        tick();
        s_rdata = 32'h2222_2222;
        settle();
        chk("rr3_m1_ack",   32'(m1_ack),  1);
        chk("rr3_m1_resp",  32'(m1_resp), 1);
        chk("rr3_m1_rdata", m1_rdata, 32'h2222_2222);
        chk("rr3_m0_resp",  32'(m0_resp), 0);
        tick();
        m0_req = 0; m1_req = 0;
        s_rdata = 32'h3333_3333;
        settle();
        chk("rr4_m0_rdata", m0_rdata, 32'h3333_3333);
        chk("rr4_err",      32'(resp_err), 0);
        tick();
        s_rdata = 32'h4444_4444;
        settle();
        chk("rr5_m1_rdata", m1_rdata, 32'h4444_4444);
        chk("rr5_m0_resp",  32'(m0_resp), 0);
        tick();
        s_resp = 0; s_rdata = 0;
        settle();
        chk("rr_count", 32'(dut.count), 0);
        chk("rr_prio",  32'(dut.prio),  0);

        // Grant lock: m1 writes alone with no ack, then m0 joins
        s_ack = 0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0100; m1_wdata = 32'h11;
        settle();
        chk("lk0_addr", s_addr, 32'h0000_0100);
        chk("lk0_ack",  32'(m1_ack), 0);
        tick();
        m0_req = 1; m0_we = 1; m0_addr = 32'h0000_0200; m0_wdata = 32'hAB;
        settle();
        chk("lk1_addr", s_addr, 32'h0000_0100);
        tick();
        settle();
        chk("lk2_addr", s_addr, 32'h0000_0100);
        tick();
        s_ack = 1;
        settle();
        chk("lk3_m1_ack", 32'(m1_ack), 1);
        chk("lk3_m0_ack", 32'(m0_ack), 0);
        chk("lk3_addr",   s_addr, 32'h0000_0100);
        tick();
        m1_req = 0;
        settle();
        chk("lk4_m0_ack", 32'(m0_ack), 1);
        chk("lk4_addr",   s_addr, 32'h0000_0200);
        chk("lk4_wdata",  s_wdata, 32'hAB);
        tick();
        m0_req = 0;

        // FIFO full: four m0 reads with responses withheld
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0300;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("full_rd%0d_ack", i), 32'(m0_ack), 1);
            tick();
        end
        m1_req = 1; m1_we = 1; m1_addr = 32'h0; m1_wdata = 32'h5A;
        settle();
        chk("full_count",   32'(dut.count), 4);
        chk("full_m0_ack",  32'(m0_ack), 0);
        chk("full_m1_ack",  32'(m1_ack), 1);
        chk("full_s_addr",  s_addr, 32'h0);
        chk("full_s_wdata", s_wdata, 32'h5A);
        tick();
        m1_req = 0;
        s_resp = 1; s_rdata = 32'h55;
        settle();
        chk("full_blk_sreq", 32'(s_req),   0);
        chk("full_blk_ack",  32'(m0_ack),  0);
        chk("full_resp",     32'(m0_resp), 1);
        chk("full_rdata",    m0_rdata, 32'h55);
        tick();
        s_resp = 0; s_rdata = 0;
        settle();
        chk("full_unblk_ack", 32'(m0_ack), 1);
        tick();
        m0_req = 0;
        settle();
        chk("full_count2", 32'(dut.count), 4);

        // Pop at full with a write accepted in the same cycle
        m1_req = 1; m1_we = 1; m1_addr = 32'h400;
        s_resp = 1; s_rdata = 32'h66;
        settle();
        chk("pp_m1_ack",  32'(m1_ack),  1);
        chk("pp_m0_resp", 32'(m0_resp), 1);
        tick();
        m1_req = 0; s_resp = 0;
        settle();
        chk("pp_count3", 32'(dut.count), 3);
        // Read accept together with a pop: count holds
        m0_req = 1; m0_we = 0; s_resp = 1; s_rdata = 32'h77;
        settle();
        chk("pp_rd_ack",  32'(m0_ack),  1);
        chk("pp_rd_resp", 32'(m0_resp), 1);
        tick();
        m0_req = 0;
        settle();
        chk("pp_count_hold", 32'(dut.count), 3);
        for (int i = 0; i < 3; i++) begin
            s_rdata = 32'h100 + 32'(i);
            settle();
            chk($sformatf("drain%0d_resp", i), 32'(m0_resp), 1);
            tick();
        end
        s_resp = 0;
        settle();
        chk("drain_count", 32'(dut.count), 0);

        // Unexpected response
        s_resp = 1; s_rdata = 32'hDEAD_BEEF;
        settle();
        chk("ux_err",      32'(resp_err), 1);
        chk("ux_m0_resp",  32'(m0_resp),  0);
        chk("ux_m1_resp",  32'(m1_resp),  0);
        chk("ux_m0_rdata", m0_rdata, 0);
        tick();
        s_resp = 0; s_rdata = 0;
        settle();
        chk("ux_err_clr", 32'(resp_err), 0);

        // Mid-operation reset: two reads outstanding, lock held, prio=1
        s_ack = 1;
        m1_req = 1; m1_we = 0; m1_addr = 32'h500;
        tick();
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h600;
        tick();
        s_ack = 0;
        tick();
        settle();
        chk("mr_count",  32'(dut.count),      2);
        chk("mr_lock",   32'(dut.lock_valid), 1);
        chk("mr_prio",   32'(dut.prio),       1);
        rst = 1;
        tick();
        rst = 0; m0_req = 0;
        settle();
        chk("mr_count0", 32'(dut.count),      0);
        chk("mr_lock0",  32'(dut.lock_valid), 0);
        chk("mr_prio0",  32'(dut.prio),       0);
        s_resp = 1; s_rdata = 32'h99;
        settle();
        chk("mr_err",     32'(resp_err), 1);
        chk("mr_m0_resp", 32'(m0_resp),  0);
        chk("mr_m1_resp", 32'(m1_resp),  0);
        tick();
        s_resp = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
